mcs4_bus_monitor: RTL

- Passive trace stage that consumes the MCS-4 system bus between the FPGA's MCS4_SYS and MCS4_CPU sides: CLK, RES_N, SYNC_N, CM_ROM_N, CM_RAM_N and DATA.
- Tracks the 8-phase instruction cycle A1 A2 A3 M1 M2 X1 X2 X3.
- Assembles one record per instruction cycle and buffers records in a FIFO with a valid/ready output.
- Used by the debug/bus-bridge logic and by simulation checkers to observe executed fetches.

---
 rtl/mcs4_bus_monitor_pkg.sv | 33 +++
 rtl/mcs4_bus_monitor_fifo.sv | 60 ++++++
 rtl/mcs4_bus_monitor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mcs4_bus_monitor_pkg.sv
// Shared types for the MCS-4 bus monitor: bus phases, lock states and the
// trace record layout.
package mcs4_bus_monitor_pkg;

    localparam int unsigned REC_W = 29;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Field order gives addr at [28:17] down to CM_ROM_N at [0].
    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic [3:0]  x2_data;
        logic [3:0]  cm_ram_n;
        logic        cm_rom_n;
    } mcs4_rec_t;

endpackage

// File: rtl/mcs4_bus_monitor_fifo.sv
// Synchronous first-word-fallthrough FIFO holding completed trace records,
// with occupancy, full and empty status.
module mcs4_mon_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = cnt;

endmodule

// File: rtl/mcs4_bus_monitor.sv
// Passive MCS-4 bus trace stage: synchronises the bus, tracks the 8-phase
// instruction cycle and queues one record per complete cycle.
module mcs4_bus_monitor
    import mcs4_bus_monitor_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DCNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RES_N,
    input  logic               ENABLE,
    input  logic               CLR_STICKY,
    input  logic               MCS4_CLK,
    input  logic               MCS4_RES_N,
    input  logic               MCS4_SYNC_N,
    input  logic               MCS4_CM_ROM_N,
    input  logic [3:0]         MCS4_CM_RAM_N,
    input  logic [3:0]         MCS4_DATA,
    output logic               REC_VALID,
    input  logic               REC_READY,
    output logic [REC_W-1:0]   REC_DATA,
    output logic [FIFO_AW:0]   FIFO_LEVEL,
    output logic               LOCKED,
    output logic               OVF,
    output logic               SYNC_ERR,
    output logic [DCNT_W-1:0]  DROP_CNT
);

    logic [11:0] bus_raw;
    logic [11:0] bus_s1;
    logic [11:0] bus_s2;
    logic        bclk_d;
    logic        bus_edge;
    logic        bus_res_n;
    logic        bus_sync_n;
    logic        bus_rom_n;
    logic [3:0]  bus_ram_n;
    logic [3:0]  bus_data;

    assign bus_raw = {MCS4_CLK, MCS4_RES_N, MCS4_SYNC_N, MCS4_CM_ROM_N,
                      MCS4_CM_RAM_N, MCS4_DATA};

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            bus_s1 <= '0;
            bus_s2 <= '0;
            bclk_d <= 1'b0;
        end else begin
            bus_s1 <= bus_raw;
            bus_s2 <= bus_s1;
            bclk_d <= bus_s2[11];
        end
    end

    assign bus_edge   = bus_s2[11] & ~bclk_d;
    assign bus_res_n  = bus_s2[10];
    assign bus_sync_n = bus_s2[9];
    assign bus_rom_n  = bus_s2[8];
    assign bus_ram_n  = bus_s2[7:4];
    assign bus_data   = bus_s2[3:0];

    lock_state_e state, state_nx;
    phase_e      p, p_nx;
    mcs4_rec_t   rec, rec_nx;
    logic        rec_ok, rec_ok_nx;
    logic        push;
    logic        err_set;

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state  <= ST_UNLOCKED;
            p      <= PH_A1;
            rec    <= '0;
            rec_ok <= 1'b0;
        end else begin
            state  <= state_nx;
            p      <= p_nx;
            rec    <= rec_nx;
            rec_ok <= rec_ok_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        p_nx      = p;
        rec_nx    = rec;
        rec_ok_nx = rec_ok;
        push      = 1'b0;
        err_set   = 1'b0;
        if (!bus_res_n) begin
            state_nx  = ST_UNLOCKED;
            p_nx      = PH_A1;
            rec_ok_nx = 1'b0;
        end else if (bus_edge) begin
            p_nx = phase_e'(p + 3'd1);
            unique case (state)
                ST_UNLOCKED: begin
                    if (!bus_sync_n) begin
                        state_nx  = ST_LOCKED;
                        p_nx      = PH_A1;
                        rec_ok_nx = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    case (p)
                        PH_A1: begin
                            rec_nx.addr[3:0] = bus_data;
                            rec_ok_nx        = 1'b1;
                        end
                        PH_A2: rec_nx.addr[7:4] = bus_data;
                        PH_A3: begin
                            rec_nx.addr[11:8] = bus_data;
                            rec_nx.cm_rom_n   = bus_rom_n;
                        end
                        PH_M1: rec_nx.opr = bus_data;
                        PH_M2: rec_nx.opa = bus_data;
                        PH_X2: begin
                            rec_nx.x2_data  = bus_data;
                            rec_nx.cm_ram_n = bus_ram_n;
                        end
                        default: ;
                    endcase
                    // rec_ok only survives from A1 if nothing realigned or unlocked since.
                    if (p == PH_X3) begin
                        rec_ok_nx = 1'b0;
                        if (!bus_sync_n) begin
                            push = ENABLE && rec_ok;
                            p_nx = PH_A1;
                        end else begin
                            err_set  = 1'b1;
                            state_nx = ST_UNLOCKED;
                        end
                    end else if (!bus_sync_n) begin
                        err_set   = 1'b1;
                        p_nx      = PH_A1;
                        rec_ok_nx = 1'b0;
                    end
                end
                default: state_nx = ST_UNLOCKED;
            endcase
        end
    end

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             ovf;
    logic             sync_err;
    logic [DCNT_W-1:0] drop_cnt;

    assign pop  = REC_VALID && REC_READY;
    assign drop = push && fifo_full && !pop;

    mcs4_mon_fifo #(
        .AW (FIFO_AW),
        .DW (REC_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RES_N),
        .wr_en   (push),
        .wr_data (rec),
        .rd_en   (pop),
        .rd_data (REC_DATA),
        .level   (FIFO_LEVEL),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A new drop or error in the clearing cycle wins over CLR_STICKY.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ovf      <= 1'b0;
            sync_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ovf      <= (ovf & ~CLR_STICKY) | drop;
            sync_err <= (sync_err & ~CLR_STICKY) | err_set;
            if (drop) begin
                if (CLR_STICKY) begin
                    drop_cnt <= DCNT_W'(1);
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DCNT_W'(1);
                end
            end else if (CLR_STICKY) begin
                drop_cnt <= '0;
            end
        end
    end

    assign REC_VALID = !fifo_empty;
    assign LOCKED    = (state == ST_LOCKED);
    assign OVF       = ovf;
    assign SYNC_ERR  = sync_err;
    assign DROP_CNT  = drop_cnt;

endmodule
